// File: rtl/ens_vote_argmax.sv
// Ensemble vote stage: sums per-class scores over NUM_MEMBERS beats, then scans
// the sums one class per cycle and presents the lowest-index argmax and its total.
module ens_vote_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int IN_BITS     = 2,
  parameter int NUM_MEMBERS = 4,
  localparam int CNT_W      = $clog2(NUM_MEMBERS * (2**IN_BITS - 1) + 1),
  localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [NUM_CLASSES*IN_BITS-1:0] s_scores,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [CLS_W-1:0]               m_class,
  output logic [CNT_W-1:0]               m_score
);

  localparam int BEAT_W = (NUM_MEMBERS > 1) ? $clog2(NUM_MEMBERS) : 1;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]   sums [NUM_CLASSES];
  logic [CLS_W-1:0]   scan_idx;
  logic [CNT_W-1:0]   best_score;
  logic [CLS_W-1:0]   best_idx;

  logic               accept;
  logic               last_beat;
  logic               last_idx;
  logic [CNT_W-1:0]   cur_sum;
  logic               take;
  logic [CNT_W-1:0]   best_score_nxt;
  logic [CLS_W-1:0]   best_idx_nxt;

  assign s_ready   = (state_q == ST_ACCUM);
  assign m_valid   = (state_q == ST_OUT);
  assign accept    = s_valid & s_ready;
  assign last_beat = (beat_cnt == BEAT_W'(NUM_MEMBERS - 1));
  assign last_idx  = (scan_idx == CLS_W'(NUM_CLASSES - 1));

  // Index 0 always loads; later indices need a strictly larger sum, so ties keep the lower class.
  always_comb begin
    cur_sum        = sums[scan_idx];
    take           = (scan_idx == '0) || (cur_sum > best_score);
    best_score_nxt = take ? cur_sum : best_score;
    best_idx_nxt   = take ? scan_idx : best_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (accept && last_beat) state_d = ST_SCAN;
      ST_SCAN:  if (last_idx)            state_d = ST_OUT;
      ST_OUT:   if (m_ready)             state_d = ST_ACCUM;
      default:                           state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      scan_idx   <= '0;
      best_score <= '0;
      best_idx   <= '0;
      m_class    <= '0;
      m_score    <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) sums[c] <= '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            for (int c = 0; c < NUM_CLASSES; c++)
              sums[c] <= sums[c] + CNT_W'(s_scores[c*IN_BITS +: IN_BITS]);
            beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
          end
        end
        ST_SCAN: begin
          best_score <= best_score_nxt;
          best_idx   <= best_idx_nxt;
          if (last_idx) begin
            scan_idx <= '0;
            m_class  <= best_idx_nxt;
            m_score  <= best_score_nxt;
          end else begin
            scan_idx <= scan_idx + CLS_W'(1);
          end
        end
        ST_OUT: begin
          // Sums are cleared only once the result is taken, so the next inference starts clean.
          if (m_ready) begin
            for (int c = 0; c < NUM_CLASSES; c++) sums[c] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ens_vote_argmax.sv
// Bench for ens_vote_argmax: table of 4-beat inferences with an expected-result queue,
// plus hand-written backpressure, reset and single-member sequences.
module tb_ens_vote_argmax;

  localparam int NC = 10;
  localparam int NM = 4;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [19:0] s_scores;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  m_class;
  logic [3:0]  m_score;

  logic        one_s_valid;
  logic        one_s_ready;
  logic [19:0] one_s_scores;
  logic        one_m_valid;
  logic        one_m_ready;
  logic [3:0]  one_m_class;
  logic [1:0]  one_m_score;

  ens_vote_argmax #(.NUM_CLASSES(NC), .IN_BITS(2), .NUM_MEMBERS(NM)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_scores(s_scores),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_score(m_score)
  );

  ens_vote_argmax #(.NUM_CLASSES(NC), .IN_BITS(2), .NUM_MEMBERS(1)) u_one (
    .clk(clk), .rst_n(rst_n),
    .s_valid(one_s_valid), .s_ready(one_s_ready), .s_scores(one_s_scores),
    .m_valid(one_m_valid), .m_ready(one_m_ready), .m_class(one_m_class),
    .m_score(one_m_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][19:0] beats;
    logic [3:0]       exp_class;
    logic [3:0]       exp_score;
    int               gap;
    int               hold;
  } vec_t;

  vec_t       tbl[12];
  logic [3:0] exp_class_q[$];
  logic [3:0] exp_score_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [19:0] beat_of(input int base, input int c1, input int v1,
                                          input int c2 = -1, input int v2 = 0);
    logic [19:0] b;
    for (int c = 0; c < NC; c++) b[c*2 +: 2] = 2'(base);
    if (c1 >= 0) b[c1*2 +: 2] = 2'(v1);
    if (c2 >= 0) b[c2*2 +: 2] = 2'(v2);
    return b;
  endfunction

  // Reference: first class holding the maximum total.
  function automatic void model(input logic [3:0][19:0] b, output logic [3:0] cls,
                                output logic [3:0] sc);
    int tot[NC];
    int bv;
    int bi;
    bv = -1;
    bi = 0;
    for (int c = 0; c < NC; c++) begin
      tot[c] = 0;
      for (int k = 0; k < NM; k++) tot[c] += int'(b[k][c*2 +: 2]);
      if (tot[c] > bv) begin
        bv = tot[c];
        bi = c;
      end
    end
    cls = 4'(bi);
    sc  = 4'(bv);
  endfunction

  task automatic drive_beats(input logic [3:0][19:0] beats, input int nbeats, input int gap,
                             input bit push, input logic [3:0] ec, input logic [3:0] es);
    int w;
    if (push) begin
      exp_class_q.push_back(ec);
      exp_score_q.push_back(es);
    end
    for (int i = 0; i < nbeats; i++) begin
      s_valid  = 1'b1;
      s_scores = beats[i];
      w = 0;
      while (!s_ready && w < 50) begin
        @(posedge clk);
        #1;
        w++;
      end
      check("accept_ready", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;
      s_valid  = 1'b0;
      s_scores = 20'($urandom);
      if (i < nbeats - 1) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Called #1 after the last accept edge: measures latency, pops the scoreboard, holds, then handshakes.
  task automatic collect(input int hold, input bit junk);
    int n;
    logic [3:0] ec, es, c0, s0;
    if (junk) begin
      s_valid  = 1'b1;
      s_scores = 20'hFFFFF;
    end
    n = 0;
    while (!m_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(NC));
    if (exp_class_q.size() == 0) begin
      check("queue_nonempty", 32'd0, 32'd1);
      ec = 'x;
      es = 'x;
    end else begin
      ec = exp_class_q.pop_front();
      es = exp_score_q.pop_front();
    end
    check("m_class", 32'(m_class), 32'(ec));
    check("m_score", 32'(m_score), 32'(es));
    c0 = m_class;
    s0 = m_score;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_stable", {24'd0, m_class, m_score}, {24'd0, c0, s0});
      check("hold_s_ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    s_valid = 1'b0;
    check("post_hs_valid", 32'(m_valid), 32'd0);
    check("post_hs_ready", 32'(s_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_class"}, 32'(m_class), 32'd0);
    check({tag, "_m_score"}, 32'(m_score), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_scores = '0;
    m_ready = 1'b0;
    one_s_valid = 1'b0;
    one_s_scores = '0;
    one_m_ready = 1'b0;

    for (int k = 0; k < 4; k++) tbl[0].beats[k] = beat_of(1, 3, 3);
    tbl[0].exp_class = 4'd3; tbl[0].exp_score = 4'd12; tbl[0].gap = 0; tbl[0].hold = 0;
    for (int k = 0; k < 4; k++) tbl[1].beats[k] = beat_of(1, 2, 2, 7, 2);
    tbl[1].exp_class = 4'd2; tbl[1].exp_score = 4'd8;  tbl[1].gap = 0; tbl[1].hold = 1;
    tbl[2] = tbl[0];
    tbl[2].gap = 1;
    for (int k = 0; k < 4; k++) tbl[3].beats[k] = beat_of(0, -1, 0);
    tbl[3].exp_class = 4'd0; tbl[3].exp_score = 4'd0;  tbl[3].gap = 0; tbl[3].hold = 0;
    for (int k = 0; k < 4; k++) tbl[4].beats[k] = beat_of(3, -1, 0);
    tbl[4].exp_class = 4'd0; tbl[4].exp_score = 4'd12; tbl[4].gap = 0; tbl[4].hold = 3;
    for (int k = 0; k < 3; k++) tbl[5].beats[k] = beat_of(0, 9, 3, 0, 3);
    tbl[5].beats[3] = beat_of(0, 9, 3, 0, 2);
    tbl[5].exp_class = 4'd9; tbl[5].exp_score = 4'd12; tbl[5].gap = 2; tbl[5].hold = 0;
    for (int k = 0; k < 4; k++) tbl[6].beats[k] = beat_of(0, 5, 3, 1, 2);
    tbl[6].exp_class = 4'd5; tbl[6].exp_score = 4'd12; tbl[6].gap = 0; tbl[6].hold = 2;
    for (int e = 7; e < 12; e++) begin
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < NC; c++) tbl[e].beats[k][c*2 +: 2] = 2'($urandom_range(0, 3));
      model(tbl[e].beats, tbl[e].exp_class, tbl[e].exp_score);
      tbl[e].gap  = $urandom_range(0, 2);
      tbl[e].hold = $urandom_range(0, 3);
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int e = 0; e < 12; e++) begin
      drive_beats(tbl[e].beats, 4, tbl[e].gap, 1'b1, tbl[e].exp_class, tbl[e].exp_score);
      collect(tbl[e].hold, 1'b0);
    end

    // Long backpressure with s_valid asserted while busy, then a clean follow-up inference.
    drive_beats(tbl[0].beats, 4, 0, 1'b1, tbl[0].exp_class, tbl[0].exp_score);
    collect(20, 1'b1);
    drive_beats(tbl[1].beats, 4, 0, 1'b1, tbl[1].exp_class, tbl[1].exp_score);
    collect(0, 1'b0);

    // Reset after two of four beats; the partial sums must not leak into the next result.
    drive_beats(tbl[4].beats, 2, 0, 1'b0, 4'd0, 4'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_accum_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_beats(tbl[0].beats, 4, 0, 1'b1, tbl[0].exp_class, tbl[0].exp_score);
    collect(0, 1'b0);

    // Reset while a result is being presented: m_valid drops without a clock edge.
    drive_beats(tbl[4].beats, 4, 0, 1'b0, 4'd0, 4'd0);
    n = 0;
    while (!m_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("out_before_reset", 32'(m_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_out_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_beats(tbl[5].beats, 4, 0, 1'b1, tbl[5].exp_class, tbl[5].exp_score);
    collect(1, 1'b0);
    check("queue_drained", 32'(exp_class_q.size()), 32'd0);

    // Single-member instance: one accept goes straight to the scan.
    one_s_valid  = 1'b1;
    one_s_scores = beat_of(1, 4, 3);
    check("one_ready", 32'(one_s_ready), 32'd1);
    @(posedge clk);
    #1;
    one_s_valid = 1'b0;
    check("one_scan_entered", 32'(one_s_ready), 32'd0);
    n = 0;
    while (!one_m_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("one_latency", 32'(n), 32'(NC));
    check("one_m_class", 32'(one_m_class), 32'd4);
    check("one_m_score", 32'(one_m_score), 32'd3);
    one_m_ready = 1'b1;
    @(posedge clk);
    #1;
    one_m_ready = 1'b0;
    check("one_post_hs_valid", 32'(one_m_valid), 32'd0);
    check("one_post_hs_ready", 32'(one_s_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
